// File: rtl/ps2_key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_scheduler
// Brief    : Turns PS/2 scan-code bytes into make/break key events, drops
//            typematic repeats and queues events in a FIFO for the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_scheduler #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [7:0]               iByte,
    input  logic                     iByteValid,
    input  logic                     iByteErr,
    input  logic                     iAck,
    input  logic                     iClrOvf,
    output logic [31:0]              oEvent,
    output logic                     oInterrupt,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOverflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [7:0]    C_EXT     = 8'hE0;
    localparam logic [7:0]    C_BRK     = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            held_vld_q, held_vld_d;
    logic            held_ext_q, held_ext_d;
    logic [7:0]      held_code_q, held_code_d;

    logic            ev_ext, ev_rel, emit, push, held_match;

    logic [9:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;
    logic            pop, full, wr_en;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        held_vld_d  = held_vld_q;
        held_ext_d  = held_ext_q;
        held_code_d = held_code_q;
        emit        = 1'b0;
        push        = 1'b0;
        ev_ext      = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        ev_rel      = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        held_match  = held_vld_q && (held_ext_q == ev_ext) && (held_code_q == iByte);

        if (iByteValid) begin
            tmo_d = '0;
            if (iByteErr || iByte == 8'h00 || iByte == 8'hFF) begin
                state_d = ST_IDLE;
            end else if (iByte == C_EXT) begin
                state_d = ev_rel ? ST_EXT_BRK : ST_EXT;
            end else if (iByte == C_BRK) begin
                state_d = ev_ext ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                emit    = 1'b1;
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == C_TO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        // A repeated make of the held key is the typematic repeat to suppress.
        if (emit) begin
            if (!ev_rel) begin
                if (!held_match) begin
                    push        = 1'b1;
                    held_vld_d  = 1'b1;
                    held_ext_d  = ev_ext;
                    held_code_d = iByte;
                end
            end else begin
                push = 1'b1;
                if (held_match) begin
                    held_vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            held_vld_q  <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            held_vld_q  <= held_vld_d;
            held_ext_q  <= held_ext_d;
            held_code_q <= held_code_d;
        end
    end

    assign pop   = iAck && (count_q != '0);
    assign full  = (count_q == C_DEPTH);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (iClrOvf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {ev_ext, ev_rel, iByte};
        end
    end

    assign oEvent     = (count_q != '0) ? {22'b0, mem_q[rd_ptr_q]} : 32'b0;
    assign oInterrupt = (count_q != '0);
    assign oCount     = count_q;
    assign oOverflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_scheduler
// Brief    : Directed and randomized bench against a queue-based event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_i;
    logic        vld_i, err_i, ack_i, clr_i;
    logic [31:0] event_o;
    logic        irq_o, ovf_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_key_event_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .iCLK(clk), .iRST(rst), .iByte(byte_i), .iByteValid(vld_i),
        .iByteErr(err_i), .iAck(ack_i), .iClrOvf(clr_i),
        .oEvent(event_o), .oInterrupt(irq_o), .oCount(count_o), .oOverflow(ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending-prefix flags with the edge they were last refreshed.
    logic [9:0] mq[$];
    bit         m_ext, m_brk, m_hv, m_hext, m_ovf;
    logic [7:0] m_hcode;
    int         m_pedge, m_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit e,
                              input bit a, input bit c, input bit r);
        bit         pop, full, push, drop;
        logic [9:0] ev;
        m_edge++;
        if (r) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_hv = 0; m_ovf = 0;
            return;
        end
        pop  = a && (mq.size() > 0);
        full = (mq.size() == DEPTH);
        push = 0;
        ev   = '0;
        if (v) begin
            if ((m_ext || m_brk) && (m_edge - m_pedge > TMO)) begin
                m_ext = 0; m_brk = 0;
            end
            if (e || b == 8'h00 || b == 8'hFF) begin
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) begin
                m_ext = 1; m_pedge = m_edge;
            end else if (b == 8'hF0) begin
                m_brk = 1; m_pedge = m_edge;
            end else begin
                ev = {m_ext, m_brk, b};
                if (!m_brk) begin
                    if (!(m_hv && m_hext == m_ext && m_hcode == b)) begin
                        push = 1; m_hv = 1; m_hext = m_ext; m_hcode = b;
                    end
                end else begin
                    push = 1;
                    if (m_hv && m_hext == m_ext && m_hcode == b) m_hv = 0;
                end
                m_ext = 0; m_brk = 0;
            end
        end
        drop = push && full && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(ev);
        if (drop) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic compare_all();
        check("count", 32'(count_o), 32'(mq.size()));
        check("irq", 32'(irq_o), 32'(mq.size() > 0));
        check("event", event_o, (mq.size() > 0) ? {22'b0, mq[0]} : 32'b0);
        check("ovf", 32'(ovf_o), 32'(m_ovf));
    endtask

    task automatic cyc(input bit v, input logic [7:0] b, input bit e,
                       input bit a, input bit c, input bit r);
        vld_i = v; byte_i = b; err_i = e; ack_i = a; clr_i = c; rst = r;
        @(posedge clk);
        model_step(v, b, e, a, c, r);
        #1;
        compare_all();
        vld_i = 0; ack_i = 0; clr_i = 0; err_i = 0; rst = 0;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1, b, 0, 0, 0, 0);
    endtask

    task automatic pop_one();
        cyc(0, 8'h00, 0, 1, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         v, e, a, c, r;
        int         ack_pct;
        rst = 1; vld_i = 0; byte_i = 0; err_i = 0; ack_i = 0; clr_i = 0;
        m_edge = 0; m_pedge = 0; m_hcode = 0;
        m_ext = 0; m_brk = 0; m_hv = 0; m_hext = 0; m_ovf = 0;

        cyc(0, 8'h00, 0, 0, 0, 1);
        check("rst_event", event_o, 32'h0);
        check("rst_count", 32'(count_o), 32'd0);

        send(8'h75);
        check("t1_event", event_o, 32'h075);
        check("t1_irq", 32'(irq_o), 32'd1);
        pop_one();
        check("t1_empty", event_o, 32'h0);

        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_count", 32'(count_o), 32'd2);
        check("t2_head0", event_o, 32'h275);
        pop_one();
        check("t2_head1", event_o, 32'h375);
        pop_one();

        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("t3_count", 32'(count_o), 32'd2);
        check("t3_head0", event_o, 32'h01C);
        pop_one();
        check("t3_head1", event_o, 32'h11C);
        pop_one();

        send(8'hE0);
        repeat (TMO) idle();
        send(8'h72);
        check("t4_event", event_o, 32'h072);
        pop_one();

        send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h15);
        check("t5_count", 32'(count_o), 32'd4);
        check("t5_ovf", 32'(ovf_o), 32'd1);
        check("t5_head", event_o, 32'h011);
        cyc(1, 8'h16, 0, 1, 0, 0);
        check("t5_count_pp", 32'(count_o), 32'd4);
        check("t5_ovf_pp", 32'(ovf_o), 32'd1);
        check("t5_h1", event_o, 32'h012);
        pop_one();
        check("t5_h2", event_o, 32'h013);
        pop_one();
        check("t5_h3", event_o, 32'h014);
        pop_one();
        check("t5_h4", event_o, 32'h016);
        pop_one();
        cyc(0, 8'h00, 0, 0, 1, 0);
        check("t5_clr", 32'(ovf_o), 32'd0);

        send(8'hF0);
        cyc(1, 8'h75, 1, 0, 0, 0);
        send(8'h75);
        check("t6_count", 32'(count_o), 32'd1);
        check("t6_event", event_o, 32'h075);
        pop_one();
        send(8'hE0);
        cyc(0, 8'h00, 0, 0, 0, 1);
        send(8'h75);
        check("t6_rst_event", event_o, 32'h075);
        pop_one();

        ack_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) ack_pct = $urandom_range(5, 70);
            if ($urandom_range(0, 199) == 0) begin
                repeat (TMO + 3) idle();
            end
            v = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: b = 8'h10 + 8'($urandom_range(1, 6));
            endcase
            e = ($urandom_range(0, 99) < 5);
            a = ($urandom_range(0, 99) < ack_pct);
            c = ($urandom_range(0, 99) < 5);
            r = ($urandom_range(0, 399) == 0);
            cyc(v, b, e, a, c, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_event_scheduler.md
Name: ps2_key_event_scheduler

Overview:
- Sits between the PS/2 bit-level receiver and the CPU interrupt/IO interface.
- Consumes validated scan-code bytes and sequences the E0/F0 prefix protocol into complete key events (make/break, extended or not).
- Suppresses typematic repeats and queues events in a small FIFO.
- Raises an interrupt while events are pending; the CPU pops events with an acknowledge strobe.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TIMEOUT_CYC, 100000, iCLK cycles allowed between a prefix byte and its following byte.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  synchronous, active-high reset.
- iByte  in  8  scan-code byte from the receiver.
- iByteValid  in  1  one-cycle strobe qualifying iByte.
- iByteErr  in  1  parity/framing error flag; meaningful only when iByteValid=1.
- iAck  in  1  CPU pop strobe; one pop per high cycle.
- iClrOvf  in  1  clears oOverflow.
- oEvent  out  32  FIFO head entry: {22'b0, ext[9], rel[8], code[7:0]}; 32'b0 when empty.
- oInterrupt  out  1  high while FIFO non-empty.
- oCount  out  $clog2(DEPTH)+1  number of queued events.
- oOverflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (iRST high at a posedge): FSM=IDLE, FIFO empty, timeout counter=0, held-key register invalid. All outputs 0. Reset overrides every other input in that cycle, including mid-sequence.
- Bytes 00 and FF are receiver error codes: discarded, FSM returns to IDLE.
- iByteValid with iByteErr=1: byte discarded, FSM returns to IDLE, no event.
- FSM states and transitions on a valid, error-free byte:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> emit {0,0,code}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit {1,0,code} -> IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> stay BRK; other -> emit {0,1,code} -> IDLE.
  - EXT_BRK: E0 or F0 -> stay EXT_BRK; other -> emit {1,1,code} -> IDLE.
- Timeout: in any state other than IDLE, the counter increments every cycle and clears on each valid byte. When it reaches TIMEOUT_CYC-1 the FSM returns to IDLE and the counter clears. No event is emitted.
- Typematic suppression: one held-key register {valid, ext, code}.
  - A make event equal to the held key is dropped.
  - Any other make event is emitted and loads the held register.
  - A break event matching the held key clears valid.
  - All break events are emitted.
- FIFO write:
  - An emitted event is written at the same posedge that samples its final byte.
  - oEvent, oInterrupt and oCount reflect it from the next cycle. Latency is 1 cycle.
- FIFO pop:
  - iAck with FIFO non-empty removes the head; the next entry appears on oEvent the following cycle.
  - iAck with FIFO empty is ignored.
- Full FIFO:
  - Push without pop: the event is dropped and oOverflow is set. The FSM and held register still update.
  - Simultaneous push and pop: both occur, count is unchanged, no overflow.
- Non-full FIFO with simultaneous push and pop: count unchanged; ordering is strict FIFO.
- Pointer wrap-around is modulo DEPTH. oCount ranges 0..DEPTH.
- oOverflow: set has priority over iClrOvf when both occur in the same cycle. Otherwise iClrOvf clears it on the next edge.

Test Plan:
- Reset, then byte 75 -> after 1 cycle oEvent=32'h075, oInterrupt=1, oCount=1; iAck -> oEvent=0, oInterrupt=0.
- Bytes E0,75 then E0,F0,75 -> two events queued, 32'h275 then 32'h375 in order.
- Bytes 1C,1C,1C (typematic), then F0,1C -> exactly two events: 32'h01C and 32'h11C.
- Byte E0, then no byte for TIMEOUT_CYC cycles, then 72 -> event 32'h072 (not extended).
- DEPTH=4: push five distinct make codes with no iAck -> oCount=4, oOverflow=1, first four codes pop in order. Push on a full FIFO with simultaneous iAck -> oCount stays 4, oOverflow unchanged.
- Byte F0, then 75 with iByteErr=1, then 75 -> one make event 32'h075. Separately, assert iRST between E0 and 75 -> the later 75 yields 32'h075.
